t5_imem: RTL

T5_IMEM -- requirements
Module: t5_imem

---
 rtl/t5_pkg.sv | 11 +
 rtl/t5_imem_if.sv | 23 ++
 rtl/t5_imem_bank.sv | 30 +++
 rtl/t5_imem.sv | 133 +++++++++++++
 4 files changed

// File: rtl/t5_pkg.sv
// Shared constants and state encoding for the t5 instruction memory.
package t5_pkg;

  localparam logic [31:0] NopWord = 32'h0000_0013;

  typedef enum logic {
    StInit,
    StRun
  } state_e;

endpackage

// File: rtl/t5_imem_if.sv
// Fetch bus between the instruction-fetch initiator (master) and the memory (slave).
interface t5_imem_if;

  logic        iwb_stb;
  logic        iwb_wre;
  logic [3:0]  iwb_sel;
  logic [29:0] iwb_adr;
  logic [31:0] iwb_dti;
  logic [31:0] iwb_dto;
  logic        iwb_ack;
  logic        iwb_err;

  modport master (
    output iwb_stb, iwb_wre, iwb_sel, iwb_adr, iwb_dti,
    input  iwb_dto, iwb_ack, iwb_err
  );

  modport slave (
    input  iwb_stb, iwb_wre, iwb_sel, iwb_adr, iwb_dti,
    output iwb_dto, iwb_ack, iwb_err
  );

endinterface

// File: rtl/t5_imem_bank.sv
// Single-port synchronous RAM, 2^AW x 32, per-byte write enables, read-first.
module t5_imem_bank #(
  parameter int unsigned AW = 10
) (
  input  logic          clk_i,
  input  logic          en_i,
  input  logic [3:0]    we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [2**AW];
  logic [31:0] rdata_q;

  // Read data captures the old word even when the same edge writes it.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      rdata_q <= mem_q[addr_i];
      for (int n = 0; n < 4; n++) begin
        if (we_i[n]) begin
          mem_q[addr_i][8*n +: 8] <= wdata_i[8*n +: 8];
        end
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/t5_imem.sv
// Instruction memory: NOP-fill sweep after reset, then single-cycle fetch bus responder.
module t5_imem
  import t5_pkg::*;
#(
  parameter int unsigned AW  = 10,
  parameter logic [31:0] NOP = NopWord
) (
  input  logic         sclk,
  input  logic         srst,
  input  logic         sena,
  t5_imem_if.slave     bus,
  output logic         ibusy
);

  localparam logic [AW-1:0] CntLast = '1;

  state_e          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;

  logic            ack_q, ack_d;
  logic            err_q, err_d;
  logic [31:0]     dto_q, dto_d;
  logic            from_bank_q, from_bank_d;

  logic            bank_en;
  logic [3:0]      bank_we;
  logic [AW-1:0]   bank_addr;
  logic [31:0]     bank_wdata;
  logic [31:0]     bank_rdata;

  logic            in_range;
  logic            req;

  assign in_range = (bus.iwb_adr >> AW) == 30'd0;
  assign req      = (state_q == StRun) && sena && bus.iwb_stb && !srst;

  always_ff @(posedge sclk) begin
    if (srst) begin
      state_q <= StInit;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StInit: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast) state_d = StRun;
      end
      StRun: ;
      default: state_d = StInit;
    endcase
  end

  always_comb begin
    ibusy      = (state_q == StInit);
    bank_en    = 1'b0;
    bank_we    = 4'h0;
    bank_addr  = bus.iwb_adr[AW-1:0];
    bank_wdata = bus.iwb_dti;
    if (state_q == StInit) begin
      bank_en    = !srst;
      bank_we    = 4'hF;
      bank_addr  = cnt_q;
      bank_wdata = NOP;
    end else if (req && in_range) begin
      bank_en = 1'b1;
      bank_we = bus.iwb_wre ? bus.iwb_sel : 4'h0;
    end
  end

  // Response registers; in-range data comes straight from the bank's registered output.
  always_comb begin
    ack_d       = ack_q;
    err_d       = err_q;
    dto_d       = dto_q;
    from_bank_d = from_bank_q;
    if (state_q == StInit) begin
      ack_d = 1'b0;
      err_d = 1'b0;
    end else if (sena) begin
      if (bus.iwb_stb) begin
        ack_d = 1'b1;
        if (in_range) begin
          err_d       = 1'b0;
          from_bank_d = 1'b1;
        end else begin
          err_d       = 1'b1;
          dto_d       = NOP;
          from_bank_d = 1'b0;
        end
      end else begin
        ack_d = 1'b0;
        err_d = 1'b0;
      end
    end
  end

  always_ff @(posedge sclk) begin
    if (srst) begin
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      dto_q       <= NOP;
      from_bank_q <= 1'b0;
    end else begin
      ack_q       <= ack_d;
      err_q       <= err_d;
      dto_q       <= dto_d;
      from_bank_q <= from_bank_d;
    end
  end

  assign bus.iwb_ack = ack_q;
  assign bus.iwb_err = err_q;
  assign bus.iwb_dto = from_bank_q ? bank_rdata : dto_q;

  t5_imem_bank #(
    .AW (AW)
  ) u_bank (
    .clk_i   (sclk),
    .en_i    (bank_en),
    .we_i    (bank_we),
    .addr_i  (bank_addr),
    .wdata_i (bank_wdata),
    .rdata_o (bank_rdata)
  );

endmodule
